wrr_arbiter: RTL

Parametrised weighted round-robin arbiter, the successor to the current fixed-width round-robin arbiter. It grants one of WIDTH requesters a one-hot grant and holds it until the downstream block acks. Each requester can receive up to a programmable number of consecutive grants (its weight) before the pointer rotates. A mode input selects strict fixed priority instead. It sits between request sources and a shared resource that returns a single-cycle ack per transaction.

---
 rtl/wrr_arbiter_if.sv | 25 ++
 rtl/wrr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between request sources and the weighted round-robin arbiter.
// The master side drives requests, weights, mode and ack; the slave side is the arbiter.
interface wrr_arbiter_if #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(WIDTH)
);
  logic                      mode;
  logic [WIDTH-1:0]          request;
  logic [WIDTH*WEIGHT_W-1:0] weight;
  logic                      ack;
  logic [WIDTH-1:0]          grant;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_id;

  modport master (
    output mode, request, weight, ack,
    input  grant, grant_valid, grant_id
  );

  modport slave (
    input  mode, request, weight, ack,
    output grant, grant_valid, grant_id
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter with registered one-hot grant held until ack.
// Each round-robin owner keeps the grant for up to its weight in consecutive acks.
module wrr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  wrr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic                  owner_fp_q, owner_fp_d;

  logic [WEIGHT_W-1:0]   credit_dec;
  logic                  reselect;
  logic [IDX_W-1:0]      sel_start;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(WIDTH - 1)) ? '0 : i + 1'b1;
  endfunction

  // First asserted request at or after start (wrapping); fixed priority scans from 0.
  function automatic logic [IDX_W:0] pick(input logic [WIDTH-1:0] req,
                                          input logic [IDX_W-1:0] start,
                                          input logic             fixed);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               base;
    found = 1'b0;
    idx   = '0;
    base  = fixed ? 0 : int'(start);
    for (int k = WIDTH - 1; k >= 0; k--) begin
      int j;
      j = (base + k) % WIDTH;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WIDTH*WEIGHT_W-1:0] w_vec,
                                                     input logic [IDX_W-1:0]          i);
    logic [WEIGHT_W-1:0] w;
    w = w_vec[int'(i)*WEIGHT_W +: WEIGHT_W];
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    owner_fp_d    = owner_fp_q;
    credit_dec    = credit_q - 1'b1;
    reselect      = 1'b0;
    sel_start     = ptr_q;

    case (state_q)
      IDLE: begin
        if (|bus.request) reselect = 1'b1;
      end
      GRANT: begin
        if (bus.ack) begin
          if (owner_fp_q) begin
            reselect = 1'b1;
          end else if (bus.request[grant_id_q] && credit_dec != '0) begin
            credit_d = credit_dec;
          end else begin
            ptr_d     = next_idx(grant_id_q);
            sel_start = next_idx(grant_id_q);
            reselect  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    {sel_found, sel_idx} = pick(bus.request, sel_start, bus.mode);

    // mode is captured per owner so a mid-grant change only affects the next selection.
    if (reselect) begin
      if (sel_found) begin
        state_d       = GRANT;
        grant_d       = WIDTH'(1) << sel_idx;
        grant_valid_d = 1'b1;
        grant_id_d    = sel_idx;
        owner_fp_d    = bus.mode;
        if (!bus.mode) credit_d = eff_weight(bus.weight, sel_idx);
      end else begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      credit_q      <= '0;
      owner_fp_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      owner_fp_q    <= owner_fp_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
endmodule
